dmem_responder: RTL and testbench

- Responder side of the processor's data-memory interface.
- Consumes `address_dmem`, `data` and `wren` from the pipeline and returns `q_dmem`.
- Backs a word-addressed RAM region plus a small MMIO region: a free-running cycle counter and a transmit FIFO drained by an external ready/valid consumer.
- Instantiated in the wrapper alongside imem and the register file.

---
 rtl/dmem_responder.sv | 147 ++++++++++++++
 tb/tb_dmem_responder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the processor pipeline.
// Serves a word-addressed RAM (address_dmem[31]=0) and a small MMIO block
// (address_dmem[31]=1): free-running cycle counter, TX FIFO with a drop counter.
// Ports:
//   clock, reset       : clock, asynchronous active-low reset
//   address_dmem, data : word address and write data from the pipeline
//   wren               : store enable
//   q_dmem             : registered read data, 1-cycle latency, read-before-write
//   tx_valid, tx_data  : registered TX FIFO head (ready/valid source)
//   tx_ready           : consumer accepts the head when tx_valid=1
module dmem_responder #(
    parameter int unsigned RAM_AW  = 12,
    parameter int unsigned FIFO_AW = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        tx_valid,
    output logic [31:0] tx_data,
    input  logic        tx_ready
);

    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;
    localparam int unsigned PW         = FIFO_AW + 1;

    localparam logic [3:0] OFF_CYCLE  = 4'h0;
    localparam logic [3:0] OFF_TXDATA = 4'h1;
    localparam logic [3:0] OFF_STATUS = 4'h2;
    localparam logic [3:0] OFF_DROP   = 4'h3;

    logic [31:0]        ram      [RAM_DEPTH];
    logic [31:0]        fifo_mem [FIFO_DEPTH];

    logic [PW-1:0]      wptr, rptr, wptr_n, rptr_n, count;
    logic [31:0]        cycle_cnt, cycle_n;
    logic [31:0]        drop_cnt, drop_n;
    logic [31:0]        q_n, status, tx_data_n;
    logic [RAM_AW-1:0]  ram_idx;
    logic [3:0]         offset;
    logic               is_mmio, full, empty;
    logic               ram_we, push, pop, push_ok, drop, drop_clr, cycle_wr;

    // Upper address bits alias RAM and MMIO and are deliberately ignored.
    logic unused_addr;
    assign unused_addr = ^address_dmem[30:RAM_AW];

    assign ram_idx = address_dmem[RAM_AW-1:0];
    assign offset  = address_dmem[3:0];
    assign is_mmio = address_dmem[31];
    assign count   = wptr - rptr;
    assign full    = (count == PW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign status  = 32'({count, full, empty});

    // Next-state logic for counters, FIFO pointers and read data.
    always_comb begin
        ram_we    = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        push_ok   = 1'b0;
        drop      = 1'b0;
        drop_clr  = 1'b0;
        cycle_wr  = 1'b0;
        cycle_n   = cycle_cnt + 32'd1;
        drop_n    = drop_cnt;
        q_n       = '0;
        wptr_n    = wptr;
        rptr_n    = rptr;
        tx_data_n = '0;

        ram_we   = wren && !is_mmio;
        cycle_wr = wren && is_mmio && (offset == OFF_CYCLE);
        push     = wren && is_mmio && (offset == OFF_TXDATA);
        drop_clr = wren && is_mmio && (offset == OFF_DROP);
        pop      = tx_valid && tx_ready;
        // A full FIFO still accepts a push when the head leaves on the same edge.
        push_ok  = push && (!full || pop);
        drop     = push && full && !pop;

        if (cycle_wr) begin
            cycle_n = data;
        end

        if (drop_clr) begin
            drop_n = drop ? 32'd1 : 32'd0;
        end else if (drop && (drop_cnt != 32'hFFFF_FFFF)) begin
            drop_n = drop_cnt + 32'd1;
        end

        wptr_n = wptr + PW'(push_ok);
        rptr_n = rptr + PW'(pop);

        // Head after the edge; a push landing on the new head slot is forwarded
        // (only possible when the FIFO is empty after any pop).
        tx_data_n = fifo_mem[rptr_n[FIFO_AW-1:0]];
        if (push_ok && (wptr[FIFO_AW-1:0] == rptr_n[FIFO_AW-1:0])) begin
            tx_data_n = data;
        end

        if (!is_mmio) begin
            q_n = ram[ram_idx];
        end else begin
            case (offset)
                OFF_CYCLE:  q_n = cycle_cnt;
                OFF_STATUS: q_n = status;
                OFF_DROP:   q_n = drop_cnt;
                default:    q_n = '0;
            endcase
        end
    end

    // Resettable state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem    <= '0;
            cycle_cnt <= '0;
            drop_cnt  <= '0;
            wptr      <= '0;
            rptr      <= '0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
        end else begin
            q_dmem    <= q_n;
            cycle_cnt <= cycle_n;
            drop_cnt  <= drop_n;
            wptr      <= wptr_n;
            rptr      <= rptr_n;
            tx_valid  <= (wptr_n != rptr_n);
            tx_data   <= tx_data_n;
        end
    end

    // Storage arrays keep their contents across reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            ram[ram_idx] <= data;
        end
        if (push_ok) begin
            fifo_mem[wptr[FIFO_AW-1:0]] <= data;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus a randomized mix, all
// checked against a queue/associative-array model of the memory map.
module tb_dmem_responder;

    localparam int unsigned RAM_AW     = 12;
    localparam int unsigned FIFO_AW    = 3;
    localparam int unsigned RAM_DEPTH  = 1 << RAM_AW;
    localparam int unsigned FIFO_DEPTH = 1 << FIFO_AW;

    localparam logic [31:0] A_CYCLE  = 32'h8000_0000;
    localparam logic [31:0] A_TXDATA = 32'h8000_0001;
    localparam logic [31:0] A_STATUS = 32'h8000_0002;
    localparam logic [31:0] A_DROP   = 32'h8000_0003;
    localparam logic [31:0] A_IDLE   = 32'h8000_000F;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] address_dmem = A_IDLE;
    logic [31:0] data = '0;
    logic        wren = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] q_dmem;
    logic        tx_valid;
    logic [31:0] tx_data;

    int checks = 0;
    int errors = 0;

    // Reference model state.
    logic [31:0] ram_m [int unsigned];
    logic [31:0] fifo_m [$];
    logic [31:0] cyc_m;
    logic [31:0] drop_m;
    logic [31:0] exp_q;
    bit          exp_known;

    dmem_responder #(.RAM_AW(RAM_AW), .FIFO_AW(FIFO_AW)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready)
    );

    always #5 clock = ~clock;

    task automatic model_reset();
        cyc_m  = '0;
        drop_m = '0;
        fifo_m.delete();
        exp_q     = '0;
        exp_known = 1'b1;
    endtask

    // Apply the memory-map rules for one edge, then advance to just after it.
    task automatic tick();
        logic [31:0] a;
        logic [3:0]  off;
        int unsigned idx;
        int          n;
        bit          do_pop, do_push, clr, dropped;
        a   = address_dmem;
        off = a[3:0];
        idx = a % RAM_DEPTH;
        n   = fifo_m.size();
        if (!a[31]) begin
            exp_known = ram_m.exists(idx);
            exp_q     = exp_known ? ram_m[idx] : 32'd0;
        end else begin
            exp_known = 1'b1;
            case (off)
                4'h0: exp_q = cyc_m;
                4'h2: begin
                    exp_q = 32'(n) * 32'd4;
                    if (n == int'(FIFO_DEPTH)) exp_q = exp_q + 32'd2;
                    if (n == 0) exp_q = exp_q + 32'd1;
                end
                4'h3: exp_q = drop_m;
                default: exp_q = 32'd0;
            endcase
        end
        do_pop  = (n > 0) && tx_ready;
        do_push = wren && a[31] && (off == 4'h1);
        clr     = wren && a[31] && (off == 4'h3);
        dropped = do_push && !do_pop && (n == int'(FIFO_DEPTH));
        if (wren && !a[31]) ram_m[idx] = data;
        cyc_m = (wren && a[31] && off == 4'h0) ? data : cyc_m + 32'd1;
        if (do_pop) void'(fifo_m.pop_front());
        if (do_push && !dropped) fifo_m.push_back(data);
        if (clr) drop_m = dropped ? 32'd1 : 32'd0;
        else if (dropped && drop_m != 32'hFFFF_FFFF) drop_m = drop_m + 32'd1;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic w, input logic r);
        address_dmem = a;
        data         = d;
        wren         = w;
        tx_ready     = r;
        tick();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (q_dmem !== 32'd0) begin errors++; $display("FAIL reset_q q_dmem=%h expected 0", q_dmem); end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid tx_valid=%b expected 0", tx_valid); end
        checks++;
        if (tx_data !== 32'd0) begin errors++; $display("FAIL reset_txdata tx_data=%h expected 0", tx_data); end
        reset = 1'b1;
        model_reset();
    endtask

    task automatic test_cycle();
        int n;
        n = int'($urandom_range(5, 15));
        for (int i = 0; i < n; i++) drive(A_IDLE, 32'd0, 1'b0, 1'b0);
        drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== exp_q || q_dmem !== 32'(n))
            begin errors++; $display("FAIL cycle_count q_dmem=%0d expected %0d", q_dmem, n); end
        drive(A_CYCLE, 32'hFFFF_FFFE, 1'b1, 1'b0);
        drive(A_IDLE, 32'd0, 1'b0, 1'b0);
        drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'hFFFF_FFFF || q_dmem !== exp_q)
            begin errors++; $display("FAIL cycle_load q_dmem=%h expected ffffffff", q_dmem); end
        drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'd0) begin errors++; $display("FAIL cycle_wrap q_dmem=%h expected 0", q_dmem); end
    endtask

    task automatic test_ram_roundtrip();
        drive(32'd5, 32'hDEAD_BEEF, 1'b1, 1'b0);
        drive(32'd5, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_rt q_dmem=%h expected deadbeef", q_dmem); end
        drive(32'd5 + 32'(RAM_DEPTH), 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ram_alias q_dmem=%h expected deadbeef", q_dmem); end
    endtask

    task automatic test_read_before_write();
        drive(32'd7, 32'h11, 1'b1, 1'b0);
        drive(32'd7, 32'h22, 1'b1, 1'b0);
        checks++;
        if (q_dmem !== 32'h11) begin errors++; $display("FAIL rbw_old q_dmem=%h expected 11", q_dmem); end
        drive(32'd7, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'h22) begin errors++; $display("FAIL rbw_new q_dmem=%h expected 22", q_dmem); end
    endtask

    task automatic test_fifo_fill_drop();
        logic [31:0] got [$];
        drive(A_DROP, 32'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 10; i++) drive(A_TXDATA, 32'(i), 1'b1, 1'b0);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 32'd1)
            begin errors++; $display("FAIL fill_head valid=%b data=%h expected 1/1", tx_valid, tx_data); end
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'h22) begin errors++; $display("FAIL fill_status q_dmem=%h expected 22", q_dmem); end
        drive(A_DROP, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'd2) begin errors++; $display("FAIL fill_drop q_dmem=%h expected 2", q_dmem); end
        for (int k = 0; k < 12; k++) begin
            if (tx_valid === 1'b1) got.push_back(tx_data);
            drive(A_IDLE, 32'd0, 1'b0, 1'b1);
            checks++;
            if (tx_valid !== (fifo_m.size() > 0))
                begin errors++; $display("FAIL drain_valid k=%0d tx_valid=%b expected %b", k, tx_valid, fifo_m.size() > 0); end
        end
        checks++;
        if (got.size() != 8) begin errors++; $display("FAIL drain_len got %0d words expected 8", got.size()); end
        for (int k = 0; k < got.size() && k < 8; k++) begin
            checks++;
            if (got[k] !== 32'(k + 1)) begin errors++; $display("FAIL drain_order k=%0d got %h expected %h", k, got[k], k + 1); end
        end
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'h1) begin errors++; $display("FAIL empty_status q_dmem=%h expected 1", q_dmem); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] words [$];
        logic [31:0] got [$];
        logic [31:0] w;
        drive(A_DROP, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            w = $urandom;
            words.push_back(w);
            drive(A_TXDATA, w, 1'b1, 1'b0);
        end
        drive(A_TXDATA, 32'hAA, 1'b1, 1'b1);
        drive(A_STATUS, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'h22) begin errors++; $display("FAIL fpp_status q_dmem=%h expected 22", q_dmem); end
        drive(A_DROP, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'd0) begin errors++; $display("FAIL fpp_drop q_dmem=%h expected 0", q_dmem); end
        for (int k = 0; k < 10; k++) begin
            if (tx_valid === 1'b1) got.push_back(tx_data);
            drive(A_IDLE, 32'd0, 1'b0, 1'b1);
        end
        checks++;
        if (got.size() != 8) begin errors++; $display("FAIL fpp_len got %0d words expected 8", got.size()); end
        for (int k = 0; k < got.size() && k < 7; k++) begin
            checks++;
            if (got[k] !== words[k + 1]) begin errors++; $display("FAIL fpp_order k=%0d got %h expected %h", k, got[k], words[k + 1]); end
        end
        if (got.size() == 8) begin
            checks++;
            if (got[7] !== 32'hAA) begin errors++; $display("FAIL fpp_last got %h expected aa", got[7]); end
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        logic        w;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 1) == 0)
                a = {1'b0, 31'($urandom) & 31'h7FFF_F000} | 32'($urandom_range(0, 15));
            else
                a = {1'b1, 27'($urandom), 4'($urandom_range(0, 4))};
            w = ($urandom_range(0, 2) != 0);
            drive(a, $urandom, w, 1'($urandom_range(0, 1)));
            if (exp_known) begin
                checks++;
                if (q_dmem !== exp_q) begin errors++; $display("FAIL rand_q k=%0d addr=%h q_dmem=%h expected %h", k, a, q_dmem, exp_q); end
            end
            checks++;
            if (tx_valid !== (fifo_m.size() > 0))
                begin errors++; $display("FAIL rand_valid k=%0d tx_valid=%b expected %b", k, tx_valid, fifo_m.size() > 0); end
            if (fifo_m.size() > 0) begin
                checks++;
                if (tx_data !== fifo_m[0]) begin errors++; $display("FAIL rand_head k=%0d tx_data=%h expected %h", k, tx_data, fifo_m[0]); end
            end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] v;
        v = $urandom;
        for (int k = 0; k < 20 && fifo_m.size() > 0; k++) drive(A_IDLE, 32'd0, 1'b0, 1'b1);
        drive(32'd100, v, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) drive(A_TXDATA, $urandom, 1'b1, 1'b0);
        drive(A_CYCLE, 32'd500, 1'b1, 1'b0);
        drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'd500 || tx_valid !== 1'b1)
            begin errors++; $display("FAIL pre_reset q_dmem=%0d valid=%b expected 500/1", q_dmem, tx_valid); end
        #3;
        reset = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL arst_valid tx_valid=%b expected 0", tx_valid); end
        checks++;
        if (q_dmem !== 32'd0) begin errors++; $display("FAIL arst_q q_dmem=%h expected 0", q_dmem); end
        checks++;
        if (tx_data !== 32'd0) begin errors++; $display("FAIL arst_txdata tx_data=%h expected 0", tx_data); end
        @(posedge clock);
        #1;
        checks++;
        if (q_dmem !== 32'd0) begin errors++; $display("FAIL arst_hold q_dmem=%h expected 0", q_dmem); end
        reset = 1'b1;
        model_reset();
        drive(A_CYCLE, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== 32'd0) begin errors++; $display("FAIL arst_cycle q_dmem=%h expected 0", q_dmem); end
        checks++;
        if (tx_valid !== 1'b0) begin errors++; $display("FAIL arst_empty tx_valid=%b expected 0", tx_valid); end
        drive(32'd100, 32'd0, 1'b0, 1'b0);
        checks++;
        if (q_dmem !== v) begin errors++; $display("FAIL arst_ram q_dmem=%h expected %h", q_dmem, v); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_cycle();
        test_ram_roundtrip();
        test_read_before_write();
        test_fifo_fill_drop();
        test_full_push_pop();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
